// File: rtl/control_pipeline.sv
// -----------------------------------------------------------------------------
// control_pipeline
//
// Receiving end of the ID-stage control bundle. The decoded control signals
// are registered through the ID/EX, EX/MEM and MEM/WB latches and each signal
// is presented in the stage that consumes it. Stall inserts a bubble into EX,
// flush kills the ID bundle, and an accepted HLT drains the pipeline and then
// raises the sticky `halted` flag. Retired instructions are counted.
//
// Optional feature macro: CTRL_RETIRE_CNT_EN
//   defined   -> num_inst counts retired (non-HLT) instructions, wraps modulo
//                2^CNT_W, and freezes once halted is set.
//   undefined -> no counter register; num_inst is tied to 0.
//
// Parameters:
//   DEST_W  width of the destination-register index
//   CNT_W   width of the retired-instruction counter
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   synchronous reset, ACTIVE-HIGH (1 = reset)
//   id_valid       in   ID holds a real instruction this cycle
//   id_alu_src     in   decoded ALU B-source select
//   id_alu_op      in   decoded ALUOp
//   id_is_branch   in   decoded branch
//   id_mem_read    in   decoded load
//   id_mem_write   in   decoded store
//   id_mem_to_reg  in   decoded WB mux select
//   id_reg_write   in   decoded register write
//   id_wwd         in   decoded WWD
//   id_halt        in   decoded HLT
//   id_dest        in   destination register [DEST_W]
//   stall          in   insert a bubble into EX (ID is held upstream)
//   flush          in   branch resolved in EX: kill the ID bundle
//   ex_alu_src     out  EX-stage ALU source
//   ex_alu_op      out  EX-stage ALUOp
//   mem_is_branch  out  MEM-stage branch
//   mem_read       out  MEM-stage read enable
//   mem_write      out  MEM-stage write enable
//   wb_reg_write   out  WB register-file write enable
//   wb_mem_to_reg  out  WB mux select
//   wb_dest        out  WB destination [DEST_W]
//   wb_wwd         out  one-cycle output-port strobe
//   halted         out  sticky, pipeline drained after HLT
//   num_inst       out  retired-instruction count [CNT_W]
//   ex_valid       out  EX stage occupied
//   mem_valid      out  MEM stage occupied
//   wb_valid       out  WB stage occupied
//
// Handshake: there is no backpressure on this block. A bundle is taken from ID
// on a rising edge exactly when id_valid & !stall & !flush & !halt_pending;
// otherwise a bubble enters EX. Every later stage advances every cycle.
// -----------------------------------------------------------------------------
module control_pipeline #(
  parameter int DEST_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic              id_alu_src,
  input  logic              id_alu_op,
  input  logic              id_is_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_wwd,
  input  logic              id_halt,
  input  logic [DEST_W-1:0] id_dest,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_alu_src,
  output logic              ex_alu_op,
  output logic              mem_is_branch,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [DEST_W-1:0] wb_dest,
  output logic              wb_wwd,
  output logic              halted,
  output logic [CNT_W-1:0]  num_inst,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid
);

  // ---------------------------------------------------------------------------
  // Per-stage control bundles. Each latch only carries the fields still needed
  // by its own stage or by a later one.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic              alu_src;
    logic              alu_op;
    logic              is_branch;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              wwd;
    logic              halt;
    logic [DEST_W-1:0] dest;
  } ex_ctrl_t;

  typedef struct packed {
    logic              is_branch;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              wwd;
    logic              halt;
    logic [DEST_W-1:0] dest;
  } mem_ctrl_t;

  typedef struct packed {
    logic              mem_to_reg;
    logic              reg_write;
    logic              wwd;
    logic              halt;
    logic [DEST_W-1:0] dest;
  } wb_ctrl_t;

  // Halt sequencing: RUN accepts bundles, DRAIN waits for the HLT to reach WB
  // while refusing new bundles, HALTED is terminal until reset.
  typedef enum logic [1:0] {
    HS_RUN    = 2'd0,
    HS_DRAIN  = 2'd1,
    HS_HALTED = 2'd2
  } halt_state_e;

  halt_state_e halt_state_q, halt_state_d;
  logic        halt_pending;

  ex_ctrl_t    id_bundle;
  logic        id_accept;

  ex_ctrl_t    ex_q, ex_d;
  logic        ex_valid_q, ex_valid_d;
  mem_ctrl_t   mem_q, mem_d;
  logic        mem_valid_q, mem_valid_d;
  wb_ctrl_t    wb_q, wb_d;
  logic        wb_valid_q, wb_valid_d;

  logic        wb_halt_retire;

  // ---------------------------------------------------------------------------
  // ID bundle capture
  // ---------------------------------------------------------------------------
  always_comb begin : id_pack
    id_bundle            = '0;
    id_bundle.alu_src    = id_alu_src;
    id_bundle.alu_op     = id_alu_op;
    id_bundle.is_branch  = id_is_branch;
    id_bundle.mem_read   = id_mem_read;
    id_bundle.mem_write  = id_mem_write;
    id_bundle.mem_to_reg = id_mem_to_reg;
    id_bundle.reg_write  = id_reg_write;
    id_bundle.wwd        = id_wwd;
    id_bundle.halt       = id_halt;
    id_bundle.dest       = id_dest;
  end

  // Flush has priority over stall, but both only ever produce a bubble, so a
  // plain AND of the qualifiers is enough.
  assign id_accept = id_valid & ~stall & ~flush & ~halt_pending;

  // ---------------------------------------------------------------------------
  // Stage advance. Flush only kills the ID bundle: the EX occupant is the
  // resolving branch and moves into MEM as usual. Bubbles carry an all-zero
  // payload so stale controls never linger in a latch.
  // ---------------------------------------------------------------------------
  always_comb begin : stage_next
    ex_valid_d = id_accept;
    ex_d       = '0;
    if (id_accept) begin
      ex_d = id_bundle;
    end

    mem_valid_d = ex_valid_q;
    mem_d       = '0;
    if (ex_valid_q) begin
      mem_d.is_branch  = ex_q.is_branch;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.wwd        = ex_q.wwd;
      mem_d.halt       = ex_q.halt;
      mem_d.dest       = ex_q.dest;
    end

    wb_valid_d = mem_valid_q;
    wb_d       = '0;
    if (mem_valid_q) begin
      wb_d.mem_to_reg = mem_q.mem_to_reg;
      wb_d.reg_write  = mem_q.reg_write;
      wb_d.wwd        = mem_q.wwd;
      wb_d.halt       = mem_q.halt;
      wb_d.dest       = mem_q.dest;
    end
  end

  always_ff @(posedge clk) begin : stage_regs
    if (reset_n) begin
      ex_valid_q  <= 1'b0;
      ex_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_q        <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_q        <= ex_d;
      mem_valid_q <= mem_valid_d;
      mem_q       <= mem_d;
      wb_valid_q  <= wb_valid_d;
      wb_q        <= wb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Halt FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  assign wb_halt_retire = wb_valid_q & wb_q.halt;

  always_ff @(posedge clk) begin : halt_state_reg
    if (reset_n) begin
      halt_state_q <= HS_RUN;
    end else begin
      halt_state_q <= halt_state_d;
    end
  end

  always_comb begin : halt_state_next
    halt_state_d = halt_state_q;
    case (halt_state_q)
      HS_RUN: begin
        // halt_pending is low in RUN, so id_accept already reflects it.
        if (id_accept && id_halt) begin
          halt_state_d = HS_DRAIN;
        end
      end
      HS_DRAIN: begin
        if (wb_halt_retire) begin
          halt_state_d = HS_HALTED;
        end
      end
      HS_HALTED: begin
        halt_state_d = HS_HALTED;
      end
      default: begin
        halt_state_d = HS_RUN;
      end
    endcase
  end

  always_comb begin : halt_state_out
    halt_pending = (halt_state_q != HS_RUN);
    halted       = (halt_state_q == HS_HALTED);
  end

  // ---------------------------------------------------------------------------
  // Stage outputs: every control is gated by its stage valid so a bubble can
  // never write the register file or memory. HLT additionally suppresses its
  // own register write and output strobe.
  // ---------------------------------------------------------------------------
  assign ex_valid      = ex_valid_q;
  assign mem_valid     = mem_valid_q;
  assign wb_valid      = wb_valid_q;

  assign ex_alu_src    = ex_valid_q & ex_q.alu_src;
  assign ex_alu_op     = ex_valid_q & ex_q.alu_op;

  assign mem_is_branch = mem_valid_q & mem_q.is_branch;
  assign mem_read      = mem_valid_q & mem_q.mem_read;
  assign mem_write     = mem_valid_q & mem_q.mem_write;

  assign wb_reg_write  = wb_valid_q & wb_q.reg_write & ~wb_q.halt;
  assign wb_mem_to_reg = wb_valid_q & wb_q.mem_to_reg;
  assign wb_dest       = wb_q.dest & {DEST_W{wb_valid_q}};
  assign wb_wwd        = wb_valid_q & wb_q.wwd & ~wb_q.halt;

  // ---------------------------------------------------------------------------
  // Retired-instruction counter
  // ---------------------------------------------------------------------------
`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // HLT is not an instruction that retires work, and the count is frozen
  // once the machine has halted.
  always_comb begin : cnt_next
    cnt_d = cnt_q;
    if (wb_valid_q && !wb_q.halt && !halted) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin : cnt_reg
    if (reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign num_inst = cnt_q;
`else
  assign num_inst = '0;
`endif

endmodule

// File: tb/tb_control_pipeline.sv
// -----------------------------------------------------------------------------
// tb_control_pipeline
//
// Bench for control_pipeline. A vector table of ID bundles with the expected
// EX occupancy is applied in a loop; accepted bundles push their expected MEM
// and WB controls into queues that a negedge monitor pops when the DUT shows
// an occupied stage. Hand-written sequences cover reset, stall, flush, HLT
// drain and counter wrap.
// -----------------------------------------------------------------------------
module tb_control_pipeline;

  localparam int DEST_W = 2;
  localparam int CNT_W  = 16;

`ifdef CTRL_RETIRE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // ctl field order: {alu_src, alu_op, is_branch, mem_read, mem_write,
  //                   mem_to_reg, reg_write, wwd, halt}
  localparam logic [8:0] C_ASRC = 9'h100;
  localparam logic [8:0] C_AOP  = 9'h080;
  localparam logic [8:0] C_BR   = 9'h040;
  localparam logic [8:0] C_MR   = 9'h020;
  localparam logic [8:0] C_MW   = 9'h010;
  localparam logic [8:0] C_M2R  = 9'h008;
  localparam logic [8:0] C_RW   = 9'h004;
  localparam logic [8:0] C_WWD  = 9'h002;
  localparam logic [8:0] C_HLT  = 9'h001;

  localparam logic [8:0] LWD = C_ASRC | C_MR | C_M2R | C_RW;
  localparam logic [8:0] SWD = C_ASRC | C_MW;
  localparam logic [8:0] ADI = C_ASRC | C_RW;
  localparam logic [8:0] ADD = C_AOP | C_RW;
  localparam logic [8:0] BRN = C_AOP | C_BR;
  localparam logic [8:0] WWD = C_WWD;
  localparam logic [8:0] HLT = C_HLT;

  typedef struct packed {
    logic              v;
    logic [8:0]        ctl;
    logic [DEST_W-1:0] dest;
    logic              stall;
    logic              flush;
    logic              acc;    // expected: bundle enters EX
  } vec_t;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              id_valid, id_alu_src, id_alu_op, id_is_branch, id_mem_read;
  logic              id_mem_write, id_mem_to_reg, id_reg_write, id_wwd, id_halt;
  logic [DEST_W-1:0] id_dest;
  logic              stall, flush;
  logic              ex_alu_src, ex_alu_op, mem_is_branch, mem_read, mem_write;
  logic              wb_reg_write, wb_mem_to_reg, wb_wwd, halted;
  logic [DEST_W-1:0] wb_dest;
  logic [CNT_W-1:0]  num_inst;
  logic              ex_valid, mem_valid, wb_valid;

  control_pipeline #(.DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .id_valid      (id_valid),
    .id_alu_src    (id_alu_src),
    .id_alu_op     (id_alu_op),
    .id_is_branch  (id_is_branch),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .id_mem_to_reg (id_mem_to_reg),
    .id_reg_write  (id_reg_write),
    .id_wwd        (id_wwd),
    .id_halt       (id_halt),
    .id_dest       (id_dest),
    .stall         (stall),
    .flush         (flush),
    .ex_alu_src    (ex_alu_src),
    .ex_alu_op     (ex_alu_op),
    .mem_is_branch (mem_is_branch),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_dest       (wb_dest),
    .wb_wwd        (wb_wwd),
    .halted        (halted),
    .num_inst      (num_inst),
    .ex_valid      (ex_valid),
    .mem_valid     (mem_valid),
    .wb_valid      (wb_valid)
  );

  // ----------------------------------------------------------------- scoreboard
  logic [2:0]        mem_exp_q[$];   // {is_branch, mem_read, mem_write}
  logic [DEST_W+3:0] wb_exp_q[$];    // {reg_write, mem_to_reg, dest, wwd, halt}
  logic [CNT_W-1:0]  exp_cnt = '0;
  logic              exp_halted = 1'b0;
  bit                mon_en = 1'b0;
  int                n_vec = 0;
  int                n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_unexpected(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got stage valid=1, expected no instruction (t=%0t)", name, $time);
  endtask

  function automatic logic [CNT_W-1:0] cnt_exp(input int n);
    return CNT_ON ? CNT_W'(n) : '0;
  endfunction

  function automatic vec_t mk(input logic v, input logic [8:0] ctl, input logic [DEST_W-1:0] dest,
                              input logic st, input logic fl, input logic acc);
    vec_t t;
    t.v = v; t.ctl = ctl; t.dest = dest; t.stall = st; t.flush = fl; t.acc = acc;
    return t;
  endfunction

  // MEM/WB monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin : mon
      logic [2:0]        me;
      logic [DEST_W+3:0] we;
      check("num_inst", num_inst, CNT_ON ? exp_cnt : '0);
      check("halted", halted, exp_halted);
      if (mem_valid) begin
        if (mem_exp_q.size() == 0) fail_unexpected("mem_unexpected");
        else begin
          me = mem_exp_q.pop_front();
          check("mem_ctrl", {mem_is_branch, mem_read, mem_write}, me);
        end
      end else begin
        check("mem_bubble", {mem_is_branch, mem_read, mem_write}, 3'b000);
      end
      if (wb_valid) begin
        if (wb_exp_q.size() == 0) fail_unexpected("wb_unexpected");
        else begin
          we = wb_exp_q.pop_front();
          check("wb_ctrl", {wb_reg_write, wb_mem_to_reg, wb_dest, wb_wwd},
                {we[DEST_W+3] & ~we[0], we[DEST_W+2], we[DEST_W+1:2], we[1] & ~we[0]});
          if (!we[0] && !exp_halted) exp_cnt = exp_cnt + 1'b1;
          if (we[0]) exp_halted = 1'b1;
        end
      end else begin
        check("wb_bubble", {wb_reg_write, wb_mem_to_reg, wb_dest, wb_wwd}, '0);
      end
    end
  end

  // ------------------------------------------------------------- driver tasks
  task automatic set_inputs(input vec_t t);
    id_valid = t.v;
    {id_alu_src, id_alu_op, id_is_branch, id_mem_read, id_mem_write,
     id_mem_to_reg, id_reg_write, id_wwd, id_halt} = t.ctl;
    id_dest = t.dest;
    stall   = t.stall;
    flush   = t.flush;
  endtask

  // Present one ID cycle; check EX one edge later.
  task automatic drive(input vec_t t);
    set_inputs(t);
    @(posedge clk);
    if (t.acc) begin
      mem_exp_q.push_back({t.ctl[6], t.ctl[5], t.ctl[4]});
      wb_exp_q.push_back({t.ctl[2], t.ctl[3], t.dest, t.ctl[1], t.ctl[0]});
    end
    @(negedge clk);
    check("ex_valid", ex_valid, t.acc);
    check("ex_alu", {ex_alu_src, ex_alu_op}, t.acc ? t.ctl[8:7] : 2'b00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk(1'b0, 9'h000, '0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic do_reset(input int n);
    mon_en  = 1'b0;
    reset_n = 1'b1;
    {id_valid, id_alu_src, id_alu_op, id_is_branch, id_mem_read, id_mem_write,
     id_mem_to_reg, id_reg_write, id_wwd, id_halt} = 10'($urandom);
    id_dest = DEST_W'($urandom);
    stall   = 1'($urandom);
    flush   = 1'($urandom);
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {ex_alu_src, ex_alu_op, mem_is_branch, mem_read, mem_write, wb_reg_write,
                         wb_mem_to_reg, wb_dest, wb_wwd, ex_valid, mem_valid, wb_valid}, '0);
    check("reset_num_inst", num_inst, 0);
    check("reset_halted", halted, 0);
    mem_exp_q.delete();
    wb_exp_q.delete();
    exp_cnt    = '0;
    exp_halted = 1'b0;
    set_inputs(mk(1'b0, 9'h000, '0, 1'b0, 1'b0, 1'b0));
    reset_n = 1'b0;
    mon_en  = 1'b1;
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    vec_t tbl [12];
    vec_t r;
    int   pulses_a, pulses_b;

    tbl[0]  = mk(1, LWD, 2'd2, 0, 0, 1);
    tbl[1]  = mk(1, ADD, 2'd1, 0, 0, 1);
    tbl[2]  = mk(1, SWD, 2'd3, 1, 0, 0);
    tbl[3]  = mk(1, SWD, 2'd3, 0, 0, 1);
    tbl[4]  = mk(0, LWD | C_WWD, 2'd1, 0, 0, 0);
    tbl[5]  = mk(1, BRN, 2'd0, 0, 0, 1);
    tbl[6]  = mk(1, ADI, 2'd1, 0, 1, 0);
    tbl[7]  = mk(1, ADI, 2'd2, 1, 1, 0);
    tbl[8]  = mk(1, WWD, 2'd0, 0, 0, 1);
    tbl[9]  = mk(1, C_ASRC | C_AOP | C_MR | C_M2R | C_RW, 2'd3, 0, 0, 1);
    tbl[10] = mk(1, ADD, 2'd2, 0, 0, 1);
    tbl[11] = mk(1, C_BR | C_MW | C_WWD, 2'd1, 0, 0, 1);

    // Reset with garbage inputs held two cycles.
    do_reset(2);

    // LWD: EX at +1, MEM at +2, WB at +3, counted after that.
    drive(mk(1, LWD, 2'd2, 0, 0, 1));
    idle(1);
    check("lwd_mem_read", mem_read, 1);
    idle(1);
    check("lwd_wb", {wb_reg_write, wb_mem_to_reg, wb_dest}, {1'b1, 1'b1, 2'd2});
    idle(1);
    check("lwd_num_inst", num_inst, cnt_exp(1));

    // SWD stalled for one cycle then re-presented: one memory write only.
    pulses_a = 0;
    drive(mk(1, SWD, 2'd3, 1, 0, 0));
    pulses_a += int'(mem_write);
    drive(mk(1, SWD, 2'd3, 0, 0, 1));
    pulses_a += int'(mem_write);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      pulses_a += int'(mem_write);
    end
    check("swd_write_pulses", pulses_a, 1);
    check("swd_num_inst", num_inst, cnt_exp(2));

    // Branch in EX with flush while ADI sits in ID.
    pulses_a = 0;
    drive(mk(1, BRN, 2'd0, 0, 0, 1));
    drive(mk(1, ADI, 2'd1, 0, 1, 0));
    check("flush_branch_in_mem", mem_is_branch, 1);
    pulses_a += int'(wb_reg_write);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      pulses_a += int'(wb_reg_write);
    end
    check("flush_adi_no_write", pulses_a, 0);
    check("flush_num_inst", num_inst, cnt_exp(3));

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) drive(tbl[i]);
    idle(3);
    check("table_num_inst", num_inst, cnt_exp(11));

    // Random traffic (no HLT).
    for (int i = 0; i < 300; i++) begin
      r.v     = ($urandom_range(0, 3) != 0);
      r.ctl   = 9'($urandom) & ~C_HLT;
      r.dest  = DEST_W'($urandom_range(0, 3));
      r.stall = ($urandom_range(0, 4) == 0);
      r.flush = ($urandom_range(0, 6) == 0);
      r.acc   = r.v & ~r.stall & ~r.flush;
      drive(r);
    end
    idle(4);

    // Counter preload to all-ones, then wrap.
    do_reset(1);
    for (int i = 0; i < 65535; i++) drive(mk(1, ADI, 2'd1, 0, 0, 1));
    idle(4);
    check("cnt_preload", num_inst, cnt_exp(65535));
    drive(mk(1, ADI, 2'd1, 0, 0, 1));
    idle(4);
    check("cnt_wrap", num_inst, 0);

    // WWD, ADI, HLT, ADI back to back.
    do_reset(1);
    pulses_a = 0;
    pulses_b = 0;
    drive(mk(1, WWD, 2'd0, 0, 0, 1));
    drive(mk(1, ADI, 2'd3, 0, 0, 1));
    pulses_a += int'(wb_wwd); pulses_b += int'(wb_reg_write);
    drive(mk(1, HLT, 2'd0, 0, 0, 1));
    pulses_a += int'(wb_wwd); pulses_b += int'(wb_reg_write);
    drive(mk(1, ADI, 2'd2, 0, 0, 0));
    pulses_a += int'(wb_wwd); pulses_b += int'(wb_reg_write);
    drive(mk(1, ADI, 2'd1, 0, 0, 0));
    pulses_a += int'(wb_wwd); pulses_b += int'(wb_reg_write);
    check("halt_not_yet", halted, 0);
    drive(mk(1, ADI, 2'd1, 0, 0, 0));
    check("halt_rise", halted, 1);
    for (int i = 0; i < 5; i++) begin
      drive(mk(1, LWD, 2'd2, 0, 0, 0));
      pulses_a += int'(wb_wwd); pulses_b += int'(wb_reg_write);
    end
    check("halt_sticky", halted, 1);
    check("halt_wwd_pulses", pulses_a, 1);
    check("halt_reg_writes", pulses_b, 1);
    check("halt_num_inst", num_inst, cnt_exp(2));

    // Reset mid-flight discards in-flight bundles and clears halt.
    do_reset(1);
    drive(mk(1, LWD, 2'd2, 0, 0, 1));
    drive(mk(1, ADD, 2'd1, 0, 0, 1));
    drive(mk(1, WWD, 2'd0, 0, 0, 1));
    do_reset(1);
    drive(mk(1, ADI, 2'd3, 0, 0, 1));
    idle(4);
    check("midreset_num_inst", num_inst, cnt_exp(1));

    check("mem_q_drained", mem_exp_q.size(), 0);
    check("wb_q_drained", wb_exp_q.size(), 0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
